// File: rtl/sar_adc_ctrl.sv
// Host-side sequencer for an 8-bit SAR ADC macro: periodic start pulses, eoc capture,
// optional 2^AVG_LOG2 averaging and a valid/ready result stream with sticky error flags.
module sar_adc_ctrl #(
    parameter int DIV_W    = 16,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] period,
    input  logic             clr_status,
    output logic             adc_start,
    input  logic             adc_eoc,
    input  logic [7:0]       adc_dout,
    output logic [7:0]       sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             busy,
    output logic             overrun,
    output logic             timeout_err
);

    localparam int ACC_W  = 8 + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [DIV_W-1:0]  per_cnt;
    logic [DIV_W-1:0]  per_q;
    logic [DIV_W-1:0]  per_eff;
    logic              tick;

    logic [1:0]        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]  conv_cnt;
    logic [7:0]        result;
    logic              eoc_hit;
    logic              timeout_hit;
    logic              block_done;
    logic              idle_clear;

    // The live period is only looked at while the count sits at 0, so a new
    // period value takes effect at the next wrap and is held for the whole run.
    assign per_eff = (per_cnt == '0) ? period : per_q;
    assign tick    = enable && (per_cnt == per_eff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt <= '0;
            per_q   <= '0;
        end else if (!enable) begin
            per_cnt <= '0;
        end else begin
            if (per_cnt == '0) begin
                per_q <= period;
            end
            per_cnt <= tick ? '0 : per_cnt + DIV_W'(1);
        end
    end

    assign eoc_hit     = (state == ST_WAIT) && adc_eoc;
    assign timeout_hit = (state == ST_WAIT) && !adc_eoc && (wait_cnt == WAIT_LAST);
    assign acc_sum     = acc + ACC_W'(adc_dout);
    assign result      = acc_sum[ACC_W-1:AVG_LOG2];
    assign block_done  = eoc_hit && (conv_cnt == LAST_CNT);
    assign idle_clear  = (state == ST_IDLE) && !enable;

    // Ticks seen outside IDLE are simply dropped; conversions never queue up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    if (eoc_hit || timeout_hit) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign adc_start = (state == ST_START);
    assign busy      = (state != ST_IDLE);

    // A timeout discards the partial block so a later average never mixes stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            conv_cnt <= '0;
        end else if (timeout_hit || block_done || idle_clear) begin
            acc      <= '0;
            conv_cnt <= '0;
        end else if (eoc_hit) begin
            acc      <= acc_sum;
            conv_cnt <= conv_cnt + CNT_W'(1);
        end
    end

    // Stream handshake: a beat transfers on a clock edge where sample_valid and
    // sample_ready are both high. Data is held stable while valid and not accepted;
    // a fresh result arriving in the handshake cycle keeps valid high with new data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else if (block_done) begin
            sample_data  <= result;
            sample_valid <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    // Sticky flags: a set event in the same cycle as clr_status wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (block_done && sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end else if (clr_status) begin
                overrun <= 1'b0;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (clr_status) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: one instance without averaging and one averaging four
// conversions share a behavioural ADC macro that answers 11 cycles after each start.
module tb_sar_adc_ctrl;

    localparam int EOC_LAT = 11;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] period;
    logic        clr_status;
    logic        adc_eoc;
    logic [7:0]  adc_dout;

    logic        start0, start2;
    logic [7:0]  data0, data2;
    logic        valid0, valid2;
    logic        ready0, ready2;
    logic        busy0, busy2;
    logic        ovr0, ovr2;
    logic        terr0, terr2;

    logic        macro_mute;
    logic [7:0]  adc_q[$];
    int          lat_cnt;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sar_adc_ctrl #(.DIV_W(16), .AVG_LOG2(0), .TIMEOUT(16)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .period(period), .clr_status(clr_status),
        .adc_start(start0), .adc_eoc(adc_eoc), .adc_dout(adc_dout),
        .sample_data(data0), .sample_valid(valid0), .sample_ready(ready0),
        .busy(busy0), .overrun(ovr0), .timeout_err(terr0)
    );

    sar_adc_ctrl #(.DIV_W(16), .AVG_LOG2(2), .TIMEOUT(16)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .period(period), .clr_status(clr_status),
        .adc_start(start2), .adc_eoc(adc_eoc), .adc_dout(adc_dout),
        .sample_data(data2), .sample_valid(valid2), .sample_ready(ready2),
        .busy(busy2), .overrun(ovr2), .timeout_err(terr2)
    );

    // ADC macro: start seen in cycle S gives a one-cycle eoc in cycle S+11.
    initial begin
        adc_eoc  = 1'b0;
        adc_dout = 8'h00;
        lat_cnt  = 0;
        forever begin
            @(negedge clk);
            adc_eoc = 1'b0;
            if (rst) begin
                lat_cnt = 0;
            end else begin
                if (lat_cnt > 0) begin
                    lat_cnt--;
                    if (lat_cnt == 0 && !macro_mute) begin
                        adc_eoc  = 1'b1;
                        adc_dout = (adc_q.size() > 0) ? adc_q.pop_front() : 8'h00;
                    end
                end
                if (start0) lat_cnt = EOC_LAT;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int budget, output int at);
        int n;
        n  = 0;
        at = -1;
        do begin
            step();
            n++;
        end while (start0 !== 1'b1 && n < budget);
        if (start0 === 1'b1) at = cyc;
        else check("start_timeout", 32'(start0), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy0 !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        if (busy0 !== 1'b0) check("idle_timeout", 32'(busy0), 32'd0);
    endtask

    initial begin
        int s, s2, r;
        logic [7:0] avg_vals[4];

        avg_vals[0] = 8'd10;
        avg_vals[1] = 8'd20;
        avg_vals[2] = 8'd30;
        avg_vals[3] = 8'd41;

        rst        = 1'b1;
        enable     = 1'b0;
        period     = 16'd49;
        clr_status = 1'b0;
        ready0     = 1'b0;
        ready2     = 1'b0;
        macro_mute = 1'b0;
        step();
        step();
        check("rst_start", 32'(start0), 32'd0);
        check("rst_valid", 32'(valid0), 32'd0);
        check("rst_data", 32'(data0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_flags", {30'd0, ovr0, terr0}, 32'd0);

        // Basic conversion, period 49: start in the 51st cycle counting the release cycle.
        adc_q.push_back(8'hA5);
        adc_q.push_back(8'hA5);
        enable = 1'b1;
        rst    = 1'b0;
        r      = cyc;
        wait_start(200, s);
        check("first_start", 32'(s - r), 32'd50);
        repeat (11) step();
        check("basic_pre_valid", 32'(valid0), 32'd0);
        step();
        check("basic_valid", 32'(valid0), 32'd1);
        check("basic_data", 32'(data0), 32'hA5);
        ready0 = 1'b1;
        step();
        check("basic_ready_clears", 32'(valid0), 32'd0);
        wait_start(100, s2);
        check("basic_spacing", 32'(s2 - s), 32'd50);
        repeat (12) step();
        check("basic2_data", 32'(data0), 32'hA5);
        check("basic2_valid", 32'(valid0), 32'd1);
        check("avg_no_out_yet", 32'(valid2), 32'd0);
        enable = 1'b0;
        repeat (3) step();

        // Averaging: the two A5 conversions above were dropped when idle with enable low.
        adc_q.delete();
        foreach (avg_vals[i]) adc_q.push_back(avg_vals[i]);
        period = 16'd19;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_start(100, s);
            repeat (11) step();
            check("avg_early", 32'(valid2), 32'd0);
            step();
            check("avg_each_data", 32'(data0), 32'(avg_vals[i]));
            check("avg_valid", 32'(valid2), (i == 3) ? 32'd1 : 32'd0);
        end
        check("avg_data", 32'(data2), 32'd25);
        enable = 1'b0;
        ready2 = 1'b1;
        step();
        check("avg_ready_clears", 32'(valid2), 32'd0);
        wait_idle(30);

        // Back-to-back: start, 11 cycles to eoc, one IDLE cycle, next start 13 cycles on.
        adc_q.delete();
        repeat (4) adc_q.push_back(8'h33);
        period = 16'd0;
        enable = 1'b1;
        wait_start(100, s);
        repeat (11) step();
        check("b2b_busy_eoc", 32'(busy0), 32'd1);
        step();
        check("b2b_idle", 32'(busy0), 32'd0);
        check("b2b_no_start_idle", 32'(start0), 32'd0);
        step();
        check("b2b_restart", 32'(start0), 32'd1);
        enable = 1'b0;
        wait_idle(30);

        // Timeout: flag appears 16 cycles after WAIT_EOC entry (cycle S+1).
        adc_q.delete();
        macro_mute = 1'b1;
        period     = 16'd29;
        enable     = 1'b1;
        wait_start(100, s);
        repeat (16) step();
        check("to_not_yet", 32'(terr0), 32'd0);
        check("to_still_busy", 32'(busy0), 32'd1);
        step();
        check("to_flag", 32'(terr0), 32'd1);
        check("to_idle", 32'(busy0), 32'd0);
        wait_start(100, s2);
        check("to_next_start", 32'(s2 - s), 32'd30);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("to_clr", 32'(terr0), 32'd0);
        enable = 1'b0;
        wait_idle(40);
        check("to_again", 32'(terr0), 32'd1);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("to_clr2", 32'(terr0), 32'd0);
        macro_mute = 1'b0;

        // Overrun with the consumer stalled.
        adc_q.delete();
        adc_q.push_back(8'h11);
        adc_q.push_back(8'h22);
        adc_q.push_back(8'h33);
        adc_q.push_back(8'h44);
        ready0 = 1'b0;
        period = 16'd19;
        enable = 1'b1;
        wait_start(100, s);
        repeat (12) step();
        check("ovr_first_data", 32'(data0), 32'h11);
        check("ovr_first_flag", 32'(ovr0), 32'd0);
        wait_start(100, s);
        repeat (12) step();
        check("ovr_data", 32'(data0), 32'h22);
        check("ovr_flag", 32'(ovr0), 32'd1);
        check("ovr_valid", 32'(valid0), 32'd1);
        wait_start(100, s);
        repeat (11) step();
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("ovr_set_wins", 32'(ovr0), 32'd1);
        check("ovr_data3", 32'(data0), 32'h33);

        // Reset in WAIT_EOC clears outputs before the next clock edge.
        wait_start(100, s);
        repeat (3) step();
        check("mid_busy", 32'(busy0), 32'd1);
        rst = 1'b1;
        #2;
        check("arst_busy", 32'(busy0), 32'd0);
        check("arst_valid", 32'(valid0), 32'd0);
        check("arst_data", 32'(data0), 32'd0);
        check("arst_flags", {30'd0, ovr0, terr0}, 32'd0);
        check("arst_start", 32'(start0), 32'd0);
        step();
        step();
        rst = 1'b0;
        r   = cyc;
        wait_start(100, s);
        check("post_rst_start", 32'(s - r), 32'd20);
        repeat (12) step();
        check("post_rst_valid", 32'(valid0), 32'd1);
        check("post_rst_data", 32'(data0), 32'h44);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
